// File: rtl/control_unit_fsm.sv
// Multi-cycle CPU control unit: registered Moore FSM that decodes opcodes and runs a BUSYWAIT memory handshake.
// Define STALL_CNT_EN to enable the saturating memory stall counter on STALL_COUNT.
module control_unit_fsm #(
    parameter int OP_WIDTH  = 8,
    parameter int MAX_WAIT  = 255,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 INSTR_VALID,
    input  logic [OP_WIDTH-1:0]  OPCODE,
    input  logic                 BUSYWAIT,
    output logic                 READY,
    output logic                 DONE,
    output logic                 ILLEGAL_OP,
    output logic                 MEM_ERROR,
    output logic [2:0]           ALUOP,
    output logic                 MUX_2SCMPL,
    output logic                 MUX_IMMD,
    output logic                 WRITEENABLE,
    output logic                 BEQ_ENABLE,
    output logic                 JUMP_ENABLE,
    output logic                 BNE_ENABLE,
    output logic                 SHIFT_ENABLE,
    output logic [1:0]           SHIFTOP,
    output logic                 READ,
    output logic                 WRITE,
    output logic                 MUX_WRITEDATA,
    output logic [CNT_WIDTH-1:0] STALL_COUNT
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [OP_WIDTH-1:0] OP_LOADI = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MOV   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_LWD   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_LWI   = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SWI   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_ROR   = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(17);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        WB       = 3'd4,
        ERR      = 3'd5
    } state_t;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       illegal;
        logic       mem_err;
        logic [2:0] aluop;
        logic       cmpl;
        logic       immd;
        logic       we;
        logic       beq;
        logic       jump;
        logic       bne;
        logic       shift;
        logic [1:0] shiftop;
        logic       rd;
        logic       wr;
        logic       mux_wd;
    } ctrl_t;

    state_t                state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    ctrl_t                 ctrl_q;
    logic                  timeout_s;
`ifdef STALL_CNT_EN
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
`endif

    function automatic logic is_mem(input logic [OP_WIDTH-1:0] op);
        return (op >= OP_LWD) && (op <= OP_SWI);
    endfunction

    function automatic ctrl_t decode(input state_t st, input logic [OP_WIDTH-1:0] op);
        ctrl_t c;
        logic  mem_immd;
        logic  load;
        c        = '0;
        mem_immd = (op == OP_LWI) || (op == OP_SWI);
        load     = (op == OP_LWD) || (op == OP_LWI);
        case (st)
            IDLE: c.ready = 1'b1;
            EXEC: begin
                c.ready = 1'b1;
                c.done  = 1'b1;
                case (op)
                    OP_LOADI: begin c.immd = 1'b1; c.we = 1'b1; end
                    OP_MOV:   c.we = 1'b1;
                    OP_ADD:   begin c.aluop = 3'b001; c.we = 1'b1; end
                    OP_SUB:   begin c.aluop = 3'b001; c.cmpl = 1'b1; c.we = 1'b1; end
                    OP_AND:   begin c.aluop = 3'b010; c.we = 1'b1; end
                    OP_OR:    begin c.aluop = 3'b011; c.we = 1'b1; end
                    OP_J:     begin c.aluop = 3'b111; c.jump = 1'b1; end
                    OP_BEQ:   begin c.aluop = 3'b001; c.cmpl = 1'b1; c.beq = 1'b1; end
                    OP_MULT:  begin c.aluop = 3'b100; c.we = 1'b1; end
                    OP_SLL:   begin c.aluop = 3'b101; c.immd = 1'b1; c.we = 1'b1; c.shift = 1'b1; c.shiftop = 2'b11; end
                    OP_SRL:   begin c.aluop = 3'b101; c.immd = 1'b1; c.we = 1'b1; c.shift = 1'b1; c.shiftop = 2'b00; end
                    OP_SRA:   begin c.aluop = 3'b110; c.immd = 1'b1; c.we = 1'b1; c.shift = 1'b1; c.shiftop = 2'b01; end
                    OP_ROR:   begin c.aluop = 3'b110; c.immd = 1'b1; c.we = 1'b1; c.shift = 1'b1; c.shiftop = 2'b10; end
                    OP_BNE:   begin c.aluop = 3'b001; c.cmpl = 1'b1; c.bne = 1'b1; end
                    default:  c.we = 1'b0;
                endcase
            end
            MEM_REQ, MEM_WAIT: begin
                c.immd = mem_immd;
                c.rd   = load;
                c.wr   = ~load;
            end
            WB: begin
                c.ready  = 1'b1;
                c.done   = 1'b1;
                c.immd   = mem_immd;
                c.we     = load;
                c.mux_wd = load;
            end
            // ERR is shared: the latched opcode tells an illegal op from a memory timeout
            ERR: begin
                c.illegal = ~is_mem(op);
                c.mem_err = is_mem(op);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign timeout_s = (MAX_WAIT != 0) && ((32'(wait_q) + 32'd1) == 32'(MAX_WAIT));

    // Next state, latched opcode, wait counter and stall counter
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        if (ctrl_q.ready && INSTR_VALID) begin
            op_d = OPCODE;
            if (OPCODE > OP_BNE) begin
                state_d = ERR;
            end else if (is_mem(OPCODE)) begin
                state_d = MEM_REQ;
            end else begin
                state_d = EXEC;
            end
        end else begin
            case (state_q)
                MEM_REQ: begin
                    state_d = MEM_WAIT;
                    wait_d  = {WAIT_W{1'b0}};
                end
                MEM_WAIT: begin
                    if (!BUSYWAIT) begin
                        state_d = WB;
                    end else if (timeout_s) begin
                        state_d = ERR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef STALL_CNT_EN
        stall_d = stall_q;
        if (((state_q == MEM_REQ) || (state_q == MEM_WAIT)) && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end else begin
            stall_d = stall_q;
        end
`endif
    end

    // State and output registers; outputs hold the decode of the state being entered
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= {OP_WIDTH{1'b0}};
            wait_q  <= {WAIT_W{1'b0}};
            ctrl_q  <= '0;
`ifdef STALL_CNT_EN
            stall_q <= {CNT_WIDTH{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            ctrl_q  <= decode(state_d, op_d);
`ifdef STALL_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign READY         = ctrl_q.ready;
    assign DONE          = ctrl_q.done;
    assign ILLEGAL_OP    = ctrl_q.illegal;
    assign MEM_ERROR     = ctrl_q.mem_err;
    assign ALUOP         = ctrl_q.aluop;
    assign MUX_2SCMPL    = ctrl_q.cmpl;
    assign MUX_IMMD      = ctrl_q.immd;
    assign WRITEENABLE   = ctrl_q.we;
    assign BEQ_ENABLE    = ctrl_q.beq;
    assign JUMP_ENABLE   = ctrl_q.jump;
    assign BNE_ENABLE    = ctrl_q.bne;
    assign SHIFT_ENABLE  = ctrl_q.shift;
    assign SHIFTOP       = ctrl_q.shiftop;
    assign READ          = ctrl_q.rd;
    assign WRITE         = ctrl_q.wr;
    assign MUX_WRITEDATA = ctrl_q.mux_wd;
`ifdef STALL_CNT_EN
    assign STALL_COUNT   = stall_q;
`else
    assign STALL_COUNT   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: per-cycle expected output vectors queued at drive time, compared after the edge.
// Instance u_a uses default MAX_WAIT; u_b uses MAX_WAIT = 4 for the timeout scenario.
module tb_control_unit_fsm;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       INSTR_VALID;
    logic [7:0] OPCODE;
    logic       BUSYWAIT;

    logic a_ready, a_done, a_ill, a_merr, a_cmpl, a_immd, a_we, a_beq, a_jmp, a_bne, a_sh, a_rd, a_wr, a_mwd;
    logic [2:0] a_alu;
    logic [1:0] a_sop;
    logic [15:0] a_stall;
    logic b_ready, b_done, b_ill, b_merr, b_cmpl, b_immd, b_we, b_beq, b_jmp, b_bne, b_sh, b_rd, b_wr, b_mwd;
    logic [2:0] b_alu;
    logic [1:0] b_sop;
    logic [15:0] b_stall;

    logic [18:0] obs_a, obs_b;
    logic [18:0] exp_q[$];
    string       tag_q[$];
    bit          use_b = 1'b0;
    int          passed = 0;
    int          total  = 0;
    int          stall_en;

    always #5 CLK = ~CLK;

    control_unit_fsm u_a (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .BUSYWAIT(BUSYWAIT),
        .READY(a_ready), .DONE(a_done), .ILLEGAL_OP(a_ill), .MEM_ERROR(a_merr), .ALUOP(a_alu),
        .MUX_2SCMPL(a_cmpl), .MUX_IMMD(a_immd), .WRITEENABLE(a_we), .BEQ_ENABLE(a_beq),
        .JUMP_ENABLE(a_jmp), .BNE_ENABLE(a_bne), .SHIFT_ENABLE(a_sh), .SHIFTOP(a_sop),
        .READ(a_rd), .WRITE(a_wr), .MUX_WRITEDATA(a_mwd), .STALL_COUNT(a_stall)
    );

    control_unit_fsm #(.MAX_WAIT(4)) u_b (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .BUSYWAIT(BUSYWAIT),
        .READY(b_ready), .DONE(b_done), .ILLEGAL_OP(b_ill), .MEM_ERROR(b_merr), .ALUOP(b_alu),
        .MUX_2SCMPL(b_cmpl), .MUX_IMMD(b_immd), .WRITEENABLE(b_we), .BEQ_ENABLE(b_beq),
        .JUMP_ENABLE(b_jmp), .BNE_ENABLE(b_bne), .SHIFT_ENABLE(b_sh), .SHIFTOP(b_sop),
        .READ(b_rd), .WRITE(b_wr), .MUX_WRITEDATA(b_mwd), .STALL_COUNT(b_stall)
    );

    assign obs_a = {a_ready, a_done, a_ill, a_merr, a_alu, a_cmpl, a_immd, a_we, a_beq, a_jmp, a_bne, a_sh, a_sop, a_rd, a_wr, a_mwd};
    assign obs_b = {b_ready, b_done, b_ill, b_merr, b_alu, b_cmpl, b_immd, b_we, b_beq, b_jmp, b_bne, b_sh, b_sop, b_rd, b_wr, b_mwd};

    // flags = {2scmpl, immd, we, beq, jump, bne, shift}; mem = {read, write, mux_writedata}
    function automatic logic [18:0] ev(input logic rdy, input logic dn, input logic il, input logic me,
                                       input logic [2:0] alu, input logic [6:0] flags,
                                       input logic [1:0] sop, input logic [2:0] mem);
        return {rdy, dn, il, me, alu, flags, sop, mem};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input logic v, input logic [7:0] op, input logic bw, input logic [18:0] e, input string tag);
        INSTR_VALID = v;
        OPCODE      = op;
        BUSYWAIT    = bw;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
        chk(tag_q.pop_front(), 32'(use_b ? obs_b : obs_a), 32'(exp_q.pop_front()));
    endtask

    initial begin
        logic [18:0] e_idle, e_lwd_mem, e_lwi_mem, e_swi_mem, e_ill, e_merr;
`ifdef STALL_CNT_EN
        stall_en = 1;
`else
        stall_en = 0;
`endif
        e_idle    = ev(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 7'b0000000, 2'b00, 3'b000);
        e_lwd_mem = ev(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 7'b0000000, 2'b00, 3'b100);
        e_lwi_mem = ev(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 7'b0100000, 2'b00, 3'b100);
        e_swi_mem = ev(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 7'b0100000, 2'b00, 3'b010);
        e_ill     = ev(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 7'b0000000, 2'b00, 3'b000);
        e_merr    = ev(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 7'b0000000, 2'b00, 3'b000);

        RESET = 1'b1; INSTR_VALID = 1'b0; OPCODE = 8'd0; BUSYWAIT = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("reset_outputs", 32'(obs_a), 32'd0);
        chk("reset_stall", 32'(a_stall), 32'd0);
        RESET = 1'b0;
        cyc(1'b0, 8'd0, 1'b0, e_idle, "idle_after_reset");

        // back-to-back ALU ops
        cyc(1'b1, 8'd2,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 7'b0010000, 2'b00, 3'b000), "add");
        cyc(1'b1, 8'd3,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 7'b1010000, 2'b00, 3'b000), "sub");
        cyc(1'b1, 8'd15, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 7'b0110001, 2'b01, 3'b000), "sra");
        cyc(1'b0, 8'd0,  1'b0, e_idle, "idle_after_alu");

        // load with five busy cycles (first one lands on MEM_REQ and is ignored)
        cyc(1'b1, 8'd8, 1'b0, e_lwd_mem, "lwd_req");
        cyc(1'b0, 8'd0, 1'b1, e_lwd_mem, "lwd_wait0");
        for (int i = 1; i <= 4; i++) cyc(1'b0, 8'd0, 1'b1, e_lwd_mem, $sformatf("lwd_wait%0d", i));
        cyc(1'b0, 8'd0, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 7'b0010000, 2'b00, 3'b001), "lwd_wb");
        chk("lwd_stall", 32'(a_stall), (stall_en != 0) ? 32'd6 : 32'd0);
        cyc(1'b0, 8'd0, 1'b0, e_idle, "idle_after_lwd");

        // store immediate, no stall, then accept straight out of WB
        cyc(1'b1, 8'd11, 1'b0, e_swi_mem, "swi_req");
        cyc(1'b0, 8'd0,  1'b0, e_swi_mem, "swi_wait");
        cyc(1'b0, 8'd0,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 7'b0100000, 2'b00, 3'b000), "swi_wb");
        cyc(1'b1, 8'd6,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 7'b0000100, 2'b00, 3'b000), "j_after_wb");
        chk("swi_stall", 32'(a_stall), (stall_en != 0) ? 32'd8 : 32'd0);
        cyc(1'b1, 8'd17, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 7'b1000010, 2'b00, 3'b000), "bne");
        cyc(1'b1, 8'd7,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 7'b1001000, 2'b00, 3'b000), "beq");
        cyc(1'b1, 8'd13, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 7'b0110001, 2'b11, 3'b000), "sll");
        cyc(1'b1, 8'd14, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 7'b0110001, 2'b00, 3'b000), "srl");
        cyc(1'b1, 8'd16, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 7'b0110001, 2'b10, 3'b000), "ror");
        cyc(1'b1, 8'd0,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 7'b0110000, 2'b00, 3'b000), "loadi");
        cyc(1'b1, 8'd1,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 7'b0010000, 2'b00, 3'b000), "mov");
        cyc(1'b1, 8'd4,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 7'b0010000, 2'b00, 3'b000), "and");
        cyc(1'b1, 8'd5,  1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 7'b0010000, 2'b00, 3'b000), "or");
        cyc(1'b1, 8'd12, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 7'b0010000, 2'b00, 3'b000), "mult");

        // illegal opcodes; the valid op offered during ERR must be ignored
        cyc(1'b1, 8'h20, 1'b0, e_ill,  "illegal_20");
        cyc(1'b1, 8'd2,  1'b1, e_idle, "idle_after_illegal");
        cyc(1'b1, 8'd18, 1'b0, e_ill,  "illegal_18");
        cyc(1'b0, 8'd0,  1'b0, e_idle, "idle_after_18");
        cyc(1'b1, 8'hFF, 1'b0, e_ill,  "illegal_ff");
        cyc(1'b0, 8'd0,  1'b0, e_idle, "idle_after_ff");

        // asynchronous reset in the middle of MEM_WAIT
        cyc(1'b1, 8'd9, 1'b1, e_lwi_mem, "lwi_req");
        cyc(1'b0, 8'd0, 1'b1, e_lwi_mem, "lwi_wait");
        #3 RESET = 1'b1;
        #1;
        chk("async_reset_read", 32'(a_rd), 32'd0);
        chk("async_reset_outputs", 32'(obs_a), 32'd0);
        chk("async_reset_stall", 32'(a_stall), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        cyc(1'b0, 8'd0, 1'b1, e_idle, "idle_after_async_reset");

        // timeout on the MAX_WAIT = 4 instance
        use_b = 1'b1;
        cyc(1'b1, 8'd9, 1'b1, e_lwi_mem, "to_req");
        cyc(1'b0, 8'd0, 1'b1, e_lwi_mem, "to_wait_enter");
        for (int i = 1; i <= 3; i++) cyc(1'b0, 8'd0, 1'b1, e_lwi_mem, $sformatf("to_wait%0d", i));
        cyc(1'b0, 8'd0, 1'b1, e_merr, "to_mem_error");
        chk("to_stall", 32'(b_stall), (stall_en != 0) ? 32'd5 : 32'd0);
        cyc(1'b0, 8'd0, 1'b1, e_idle, "to_ready_after");
        cyc(1'b0, 8'd0, 1'b0, e_idle, "to_idle_hold");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
